serial_magcom: RTL and testbench
================================

Name: serial_magcom

Overview:
Parametrised, multi-cycle magnitude comparator. It compares two WIDTH-bit operands MSB-first, examining DIGIT bits per clock. It stops early at the first differing digit and supports signed or unsigned mode per operation. It is the sequential successor to the single-cycle 4-bit lt/gt/eq comparator, for wide operands where a full-width compare would break timing.

Parameters:
WIDTH, 16, operand width in bits; must be a multiple of DIGIT.
DIGIT, 4, bits compared per clock; legal values 1..WIDTH.
NDIG, WIDTH/DIGIT, derived digit count; localparam, not overridable.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request a compare; sampled only when busy=0.
a  input  WIDTH  operand A; sampled on the accepting edge.
b  input  WIDTH  operand B; sampled on the accepting edge.
is_signed  input  1  1 = two's-complement compare, 0 = unsigned; sampled with a/b.
busy  output  1  high while a compare is in progress.
done  output  1  one-cycle pulse when results update.
lt  output  1  A<B for the last completed compare.
gt  output  1  A>B for the last completed compare.
eq  output  1  A==B for the last completed compare.
cycles  output  $clog2(NDIG+1)  digits examined in the last compare (1..NDIG).

Behaviour:
- Reset (rst=1 at an edge): state IDLE; busy, done, lt, gt, eq = 0; cycles = 0; internal shift registers cleared. Reset mid-operation aborts the compare. No done pulse follows the abort.
- FSM states: IDLE, RUN.
  - IDLE, start=1 → latch a, b, is_signed into shift regs sa, sb. Clear the digit counter. Go to RUN; busy=1 from the next cycle.
  - IDLE, start=0 → stay in IDLE.
- RUN, every cycle: compare the top DIGIT bits of sa and sb as unsigned values.
  - Signed mode: invert the MSB of both operands at latch time (offset-binary). An unsigned compare then yields the signed order. No other arithmetic is needed.
  - Digits differ → set lt/gt from that digit and clear eq. Set cycles = digits examined including this one. Assert done for one cycle and return to IDLE.
  - Digits equal and not the last digit → shift sa and sb left by DIGIT, increment the counter, stay in RUN.
  - Digits equal and the last digit → eq=1, lt=gt=0, cycles=NDIG, done pulse, return to IDLE.
- Latency: if start is accepted at edge t, results and done appear after edge t+N, where N = index of the first differing digit + 1, or NDIG if equal. Best case 1, worst case NDIG.
- Exactly one of lt/gt/eq is 1 after any completed compare. All three are 0 only after reset and before the first completion.
- lt, gt, eq and cycles hold their values until the next done edge. Accepting a new start does not clear them.
- start while busy=1: ignored, with no queueing. a, b and is_signed are don't-care at that time.
- start in the same cycle done=1: accepted, since the FSM is already in IDLE. This gives back-to-back operation with no bubble.
- start and rst asserted together: reset wins.
- DIGIT=WIDTH: every compare takes 1 cycle. This mode degenerates to the original single-cycle comparator, registered.

Decomposition:
- Package magcom_pkg holds:
  - state enum {S_IDLE, S_RUN};
  - result enum {CMP_LT, CMP_EQ, CMP_GT};
  - a function for counter width (clog2 of NDIG+1).
- One sub-module, digit_cmp: combinational, parameter DIGIT, inputs x and y, outputs lt/gt/eq for a single digit. It is instantiated once on the top digit of the shift registers.
- The FSM, shift registers and result registers live in serial_magcom.

Test Plan:
1. WIDTH=16, DIGIT=4, unsigned; a=0x7007, b=0x7007, start pulse → busy for 4 cycles, done after edge t+4, eq=1, lt=gt=0, cycles=4.
2. Unsigned, a=0x4000, b=0x6000 → done after edge t+1, lt=1, cycles=1. Then a=0x0009, b=0x0008 → gt=1, cycles=4.
3. a=0xFFFF, b=0x0001: is_signed=1 → lt=1, cycles=1; is_signed=0 → gt=1, cycles=1. Also a=0x8000, b=0x7FFF, signed → lt=1.
4. Start a=0x1234, b=0x1235; pulse start again with a=0, b=0 while busy → second start ignored; result gt=0, lt=1, cycles=4. Then start in the done cycle with a=0xA000, b=0x1000 → accepted, gt=1 one cycle later.
5. Start a=0x1111, b=0x1111; assert rst at the second RUN cycle → next cycle busy=0, lt=gt=eq=0, cycles=0, and no done pulse ever appears.
6. DIGIT=16 build: a=10, b=1 → done after edge t+1, gt=1, cycles=1. Random 1000-vector sweep in both modes checked against a reference model of A<B, A>B, A==B.

Source files
------------

// File: rtl/magcom_pkg.sv
// magcom_pkg: shared types and helpers for the serial magnitude comparator.
// Contents: FSM state enum, comparison result enum, counter width helper.
package magcom_pkg;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    typedef enum logic [1:0] {CMP_LT, CMP_EQ, CMP_GT} cmp_t;

    // Bits needed to hold a digit count of 0..ndig.
    function automatic int cnt_w(input int ndig);
        return $clog2(ndig + 1);
    endfunction

endpackage

// File: rtl/digit_cmp.sv
// digit_cmp: combinational unsigned compare of one DIGIT-bit digit.
// Ports: x, y = digits to compare; lt/gt/eq = x<y, x>y, x==y.
module digit_cmp #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    output logic             lt,
    output logic             gt,
    output logic             eq
);

    assign lt = x < y;
    assign gt = x > y;
    assign eq = x == y;

endmodule

// File: rtl/serial_magcom.sv
// serial_magcom: multi-cycle MSB-first magnitude comparator with early exit.
// Ports: clk/rst (sync, active-high); start/a/b/is_signed = request and operands;
//        busy = compare in progress; done = one-cycle result strobe;
//        lt/gt/eq/cycles = result of the last completed compare.
module serial_magcom
    import magcom_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [WIDTH-1:0]                    a,
    input  logic [WIDTH-1:0]                    b,
    input  logic                                is_signed,
    output logic                                busy,
    output logic                                done,
    output logic                                lt,
    output logic                                gt,
    output logic                                eq,
    output logic [cnt_w(WIDTH/DIGIT)-1:0]       cycles
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = cnt_w(NDIG);

    state_t           state;
    logic [WIDTH-1:0] sa, sb;
    logic [CW-1:0]    cnt;
    logic             dlt, dgt, deq;
    logic             last;

    // Flipping the MSB maps two's-complement order onto unsigned order.
    logic [WIDTH-1:0] flip;
    assign flip = WIDTH'(is_signed) << (WIDTH - 1);

    assign last = cnt == CW'(NDIG - 1);

    digit_cmp #(.DIGIT(DIGIT)) u_dig (
        .x  (sa[WIDTH-1 -: DIGIT]),
        .y  (sb[WIDTH-1 -: DIGIT]),
        .lt (dlt),
        .gt (dgt),
        .eq (deq)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            lt     <= 1'b0;
            gt     <= 1'b0;
            eq     <= 1'b0;
            cycles <= '0;
            sa     <= '0;
            sb     <= '0;
            cnt    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    sa    <= a ^ flip;
                    sb    <= b ^ flip;
                    cnt   <= '0;
                    busy  <= 1'b1;
                    state <= S_RUN;
                end
                S_RUN: if (!deq || last) begin
                    lt     <= dlt;
                    gt     <= dgt;
                    eq     <= deq;
                    cycles <= cnt + CW'(1);
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end else begin
                    sa  <= sa << DIGIT;
                    sb  <= sb << DIGIT;
                    cnt <= cnt + CW'(1);
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_magcom.sv
// tb_serial_magcom: self-checking bench for serial_magcom (DIGIT=4 and DIGIT=16 builds).
module tb_serial_magcom;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start4 = 1'b0, start16 = 1'b0, is_signed = 1'b0;
    logic [15:0] a = '0, b = '0;

    logic       busy4, done4, lt4, gt4, eq4;
    logic [2:0] cyc4;
    logic       busy16, done16, lt16, gt16, eq16;
    logic [0:0] cyc16;

    int checks = 0;
    int errors = 0;

    logic       sel = 1'b0;
    logic [2:0] prev4 = '0, prev16 = '0;
    logic       o_busy, o_done;
    logic [2:0] o_res, o_cyc;

    always #5 clk = ~clk;

    serial_magcom #(.WIDTH(16), .DIGIT(4)) u4 (
        .clk(clk), .rst(rst), .start(start4), .a(a), .b(b), .is_signed(is_signed),
        .busy(busy4), .done(done4), .lt(lt4), .gt(gt4), .eq(eq4), .cycles(cyc4)
    );

    serial_magcom #(.WIDTH(16), .DIGIT(16)) u16 (
        .clk(clk), .rst(rst), .start(start16), .a(a), .b(b), .is_signed(is_signed),
        .busy(busy16), .done(done16), .lt(lt16), .gt(gt16), .eq(eq16), .cycles(cyc16)
    );

    always_comb begin
        o_busy = sel ? busy16 : busy4;
        o_done = sel ? done16 : done4;
        o_res  = sel ? {lt16, gt16, eq16} : {lt4, gt4, eq4};
        o_cyc  = sel ? {2'b00, cyc16} : cyc4;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected order from integer arithmetic; expected digit count from the
    // position of the most significant differing digit of a^b.
    task automatic model(input logic [15:0] x, input logic [15:0] y, input logic s,
                         input int dig, output logic [2:0] r, output int n);
        longint sx, sy;
        int     ndig, m, d;
        ndig = 16 / dig;
        m    = (1 << dig) - 1;
        d    = 32'(x ^ y);
        sx   = s ? longint'($signed(x)) : longint'(x);
        sy   = s ? longint'($signed(y)) : longint'(y);
        r    = sx < sy ? 3'b100 : sx > sy ? 3'b010 : 3'b001;
        n    = ndig;
        for (int k = ndig - 1; k >= 0; k--)
            if (((d >> (16 - dig * (k + 1))) & m) != 0) n = k + 1;
    endtask

    task automatic cmp(input logic s_el, input logic [15:0] x, input logic [15:0] y,
                       input logic sg, input string tag);
        logic [2:0] er, held;
        int         en, lat;
        sel  = s_el;
        held = s_el ? prev16 : prev4;
        model(x, y, sg, s_el ? 16 : 4, er, en);
        @(negedge clk);
        a = x; b = y; is_signed = sg;
        if (s_el) start16 = 1'b1; else start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0; start16 = 1'b0;
        check({tag, " busy"}, 32'(o_busy), 1);
        check({tag, " held"}, 32'(o_res), 32'(held));
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(posedge clk); #1;
            if (o_done) lat = i;
        end
        check({tag, " latency"}, lat, en);
        check({tag, " result"}, 32'(o_res), 32'(er));
        check({tag, " cycles"}, 32'(o_cyc), en);
        check({tag, " idle"}, 32'(o_busy), 0);
        if (s_el) prev16 = er; else prev4 = er;
    endtask

    initial begin
        logic [15:0] x, y;
        int          seen;

        repeat (2) @(posedge clk);
        #1;
        check("reset u4", {busy4, done4, lt4, gt4, eq4, cyc4}, 0);
        check("reset u16", {busy16, done16, lt16, gt16, eq16, cyc16}, 0);
        @(negedge clk);
        rst = 1'b0;

        cmp(0, 16'h7007, 16'h7007, 0, "equal");
        cmp(0, 16'h4000, 16'h6000, 0, "lt top");
        cmp(0, 16'h0009, 16'h0008, 0, "gt last");
        cmp(0, 16'hFFFF, 16'h0001, 1, "signed neg");
        cmp(0, 16'hFFFF, 16'h0001, 0, "unsigned ffff");
        cmp(0, 16'h8000, 16'h7FFF, 1, "signed min");
        cmp(0, 16'h7FFF, 16'h8000, 1, "signed max");

        // Start while busy must be ignored.
        sel = 0;
        @(negedge clk);
        a = 16'h1234; b = 16'h1235; is_signed = 0; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        @(negedge clk);
        a = 16'h0000; b = 16'h0000; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        seen = 0;
        for (int i = 2; i <= 20 && seen == 0; i++) begin
            @(posedge clk); #1;
            if (done4) seen = i;
        end
        check("busy start latency", seen, 4);
        check("busy start result", {lt4, gt4, eq4}, 3'b100);
        check("busy start cycles", 32'(cyc4), 4);

        // Start in the done cycle is accepted with no bubble.
        a = 16'hA000; b = 16'h1000; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        check("b2b busy", 32'(busy4), 1);
        check("b2b held", {lt4, gt4, eq4}, 3'b100);
        @(posedge clk); #1;
        check("b2b done", 32'(done4), 1);
        check("b2b result", {lt4, gt4, eq4}, 3'b010);
        check("b2b cycles", 32'(cyc4), 1);
        prev4 = 3'b010;

        // Reset during the second RUN cycle aborts with no done pulse.
        @(negedge clk);
        a = 16'h1111; b = 16'h1111; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort state", {busy4, done4, lt4, gt4, eq4, cyc4}, 0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done4) seen++;
        end
        check("abort no done", seen, 0);
        prev4 = '0; prev16 = '0;

        cmp(1, 16'd10, 16'd1, 0, "d16 gt");
        cmp(1, 16'hFFFF, 16'h0001, 1, "d16 signed");
        cmp(1, 16'h5555, 16'h5555, 1, "d16 equal");

        for (int i = 0; i < 2000; i++) begin
            x = 16'($urandom);
            case ($urandom_range(0, 3))
                0: y = x;
                1: y = x ^ (16'h1 << $urandom_range(0, 15));
                default: y = 16'($urandom);
            endcase
            cmp(i[1], x, y, i[0], "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
